// File: rtl/tank_motion.sv
// tank_motion: per-player tank movement controller, stepped once per video frame.
//
// Ports
//   frame_clk          frame-rate clock, all state updates on its rising edge
//   Reset_n            asynchronous active-low reset
//   keycode0/keycode1  HID keycodes, slot 0 has priority over slot 1
//   speed_pickup       one-frame pulse, (re)loads the boost timer
//   respawn            one-frame pulse, returns the tank to centre with a spawn lock
//   barrier_collision  {up, down, left, right} blocked flags from the collision logic
//   pos_x/pos_y        tank centre
//   size               tank half-size (constant)
//   direction          00 left, 01 right, 10 down, 11 up
//   moving             position changed on the last edge
//   boost_active       boost timer non-zero
//   spawning           spawn lock active
module tank_motion #(
    parameter int unsigned X_CENTER     = 480,
    parameter int unsigned Y_CENTER     = 240,
    parameter int unsigned X_MIN        = 1,
    parameter int unsigned X_MAX        = 639,
    parameter int unsigned Y_MIN        = 1,
    parameter int unsigned Y_MAX        = 479,
    parameter int unsigned SIZE         = 8,
    parameter int unsigned KEY_LEFT     = 80,
    parameter int unsigned KEY_RIGHT    = 79,
    parameter int unsigned KEY_DOWN     = 81,
    parameter int unsigned KEY_UP       = 82,
    parameter int unsigned BASE_STEP    = 2,
    parameter int unsigned BOOST_STEP   = 3,
    parameter int unsigned RAMP_FRAMES  = 4,
    parameter int unsigned BOOST_FRAMES = 600,
    parameter int unsigned SPAWN_FRAMES = 60,
    parameter logic [1:0]  DIR_RESET    = 2'b00
) (
    input  logic       frame_clk,
    input  logic       Reset_n,
    input  logic [7:0] keycode0,
    input  logic [7:0] keycode1,
    input  logic       speed_pickup,
    input  logic       respawn,
    input  logic [3:0] barrier_collision,
    output logic [9:0] pos_x,
    output logic [9:0] pos_y,
    output logic [9:0] size,
    output logic [1:0] direction,
    output logic       moving,
    output logic       boost_active,
    output logic       spawning
);
    localparam int unsigned CntW   = $clog2(RAMP_FRAMES + 1);
    localparam int unsigned BoostW = (BOOST_FRAMES > 0) ? $clog2(BOOST_FRAMES + 1) : 1;
    localparam int unsigned SpawnW = (SPAWN_FRAMES > 0) ? $clog2(SPAWN_FRAMES + 1) : 1;

    // Lowest/highest legal centre coordinates.
    localparam logic [9:0] XLo = 10'(X_MIN + SIZE + 1);
    localparam logic [9:0] XHi = 10'(X_MAX - SIZE);
    localparam logic [9:0] YLo = 10'(Y_MIN + SIZE + 1);
    localparam logic [9:0] YHi = 10'(Y_MAX - SIZE);

    typedef enum logic [1:0] {StIdle, StRamp, StCruise, StSpawn} state_e;

    state_e              state_q, state_d;
    logic [9:0]          pos_x_q, pos_x_d, pos_y_q, pos_y_d;
    logic [1:0]          dir_q, dir_d;
    logic [CntW-1:0]     cnt_q, cnt_d, cnt_next;
    logic [BoostW-1:0]   boost_q, boost_d;
    logic [SpawnW-1:0]   spawn_q, spawn_d;
    logic                moving_q, moving_d;

    // Returns {valid, dir}.
    function automatic logic [2:0] decode_key(input logic [7:0] kc);
        logic [2:0] r;
        r = 3'b000;
        if (kc == 8'(KEY_LEFT))       r = 3'b100;
        else if (kc == 8'(KEY_RIGHT)) r = 3'b101;
        else if (kc == 8'(KEY_DOWN))  r = 3'b110;
        else if (kc == 8'(KEY_UP))    r = 3'b111;
        return r;
    endfunction

    logic [2:0]  dec0, dec1, dec;
    logic        req, blocked, locked, cruise_same;
    logic [1:0]  req_dir;
    logic [9:0]  step;
    logic [10:0] px, py, step11;

    assign dec0    = decode_key(keycode0);
    assign dec1    = decode_key(keycode1);
    assign dec     = dec0[2] ? dec0 : dec1;
    assign req     = dec[2];
    assign req_dir = dec[1:0];

    // Comparisons run at 11 bits so that pos +/- step never wraps.
    assign px     = {1'b0, pos_x_q};
    assign py     = {1'b0, pos_y_q};
    assign step11 = {1'b0, step};

    assign cruise_same = (state_q == StCruise) && (req_dir == dir_q);
    assign step = (boost_q != '0) ? 10'(BOOST_STEP) : (cruise_same ? 10'(BASE_STEP) : 10'd1);
    // The spawn lock releases on the edge where the timer runs out, so that edge may move.
    assign locked   = (state_q == StSpawn) && (spawn_q > SpawnW'(1));
    // Leaving IDLE/SPAWN or turning out of CRUISE counts as the first ramp move.
    assign cnt_next = (state_q == StRamp) ? cnt_q + CntW'(1) : CntW'(1);

    always_comb begin
        blocked = 1'b0;
        unique case (req_dir)
            2'b00: blocked = barrier_collision[1] || (px < {1'b0, XLo});
            2'b01: blocked = barrier_collision[0] || (px >= {1'b0, XHi});
            2'b10: blocked = barrier_collision[2] || (py >= {1'b0, YHi});
            2'b11: blocked = barrier_collision[3] || (py < {1'b0, YLo});
        endcase
    end

    always_comb begin
        state_d  = state_q;
        pos_x_d  = pos_x_q;
        pos_y_d  = pos_y_q;
        dir_d    = dir_q;
        cnt_d    = cnt_q;
        boost_d  = boost_q;
        spawn_d  = spawn_q;
        moving_d = 1'b0;

        if (respawn) begin
            // A pickup in the same frame is intentionally dropped.
            state_d = StSpawn;
            pos_x_d = 10'(X_CENTER);
            pos_y_d = 10'(Y_CENTER);
            dir_d   = DIR_RESET;
            cnt_d   = '0;
            boost_d = '0;
            spawn_d = SpawnW'(SPAWN_FRAMES);
        end else begin
            if (speed_pickup) begin
                boost_d = BoostW'(BOOST_FRAMES);
            end else if (boost_q != '0) begin
                boost_d = boost_q - BoostW'(1);
            end
            if (spawn_q != '0) begin
                spawn_d = spawn_q - SpawnW'(1);
            end

            if (!locked) begin
                if (!req) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end else begin
                    dir_d = req_dir;
                    if (blocked) begin
                        state_d = StIdle;
                        cnt_d   = '0;
                    end else begin
                        if (cruise_same) begin
                            state_d = StCruise;
                        end else begin
                            cnt_d   = cnt_next;
                            state_d = (cnt_next >= CntW'(RAMP_FRAMES)) ? StCruise : StRamp;
                        end
                        unique case (req_dir)
                            2'b00: pos_x_d = (px < {1'b0, XLo} + step11) ? XLo : pos_x_q - step;
                            2'b01: pos_x_d = (px + step11 > {1'b0, XHi}) ? XHi : pos_x_q + step;
                            2'b10: pos_y_d = (py + step11 > {1'b0, YHi}) ? YHi : pos_y_q + step;
                            2'b11: pos_y_d = (py < {1'b0, YLo} + step11) ? YLo : pos_y_q - step;
                        endcase
                    end
                end
            end
            // A clamped move that lands where it started does not count as moving.
            moving_d = (pos_x_d != pos_x_q) || (pos_y_d != pos_y_q);
        end
    end

    always_ff @(posedge frame_clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q  <= StIdle;
            pos_x_q  <= 10'(X_CENTER);
            pos_y_q  <= 10'(Y_CENTER);
            dir_q    <= DIR_RESET;
            cnt_q    <= '0;
            boost_q  <= '0;
            spawn_q  <= '0;
            moving_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pos_x_q  <= pos_x_d;
            pos_y_q  <= pos_y_d;
            dir_q    <= dir_d;
            cnt_q    <= cnt_d;
            boost_q  <= boost_d;
            spawn_q  <= spawn_d;
            moving_q <= moving_d;
        end
    end

    assign pos_x        = pos_x_q;
    assign pos_y        = pos_y_q;
    assign size         = 10'(SIZE);
    assign direction    = dir_q;
    assign moving       = moving_q;
    assign boost_active = (boost_q != '0);
    assign spawning     = (state_q == StSpawn);

endmodule

// File: tb/tb_tank_motion.sv
// Self-checking bench for tank_motion (default parameters).
module tb_tank_motion;
    logic       frame_clk = 1'b0;
    logic       Reset_n;
    logic [7:0] keycode0, keycode1;
    logic       speed_pickup, respawn;
    logic [3:0] barrier_collision;
    logic [9:0] pos_x, pos_y, size;
    logic [1:0] direction;
    logic       moving, boost_active, spawning;

    always #5 frame_clk = ~frame_clk;

    tank_motion dut (
        .frame_clk         (frame_clk),
        .Reset_n           (Reset_n),
        .keycode0          (keycode0),
        .keycode1          (keycode1),
        .speed_pickup      (speed_pickup),
        .respawn           (respawn),
        .barrier_collision (barrier_collision),
        .pos_x             (pos_x),
        .pos_y             (pos_y),
        .size              (size),
        .direction         (direction),
        .moving            (moving),
        .boost_active      (boost_active),
        .spawning          (spawning)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at t=%0t",
                     name, act, act, exp, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge frame_clk);
        #1;
    endtask

    task automatic clear_inputs();
        keycode0          = 8'd0;
        keycode1          = 8'd0;
        speed_pickup      = 1'b0;
        respawn           = 1'b0;
        barrier_collision = 4'h0;
    endtask

    // Asynchronous reset pulse between edges.
    task automatic pulse_reset();
        Reset_n = 1'b0;
        #2;
        Reset_n = 1'b1;
    endtask

    // ---------------- behavioural reference model ----------------
    // Time-based: boost and spawn windows are kept as absolute frame numbers.
    int m_f, m_x, m_y, m_dir, m_mom, m_boost_end, m_rf;
    bit m_moving, m_boost, m_spawn;

    function automatic int key_dir(input logic [7:0] kc);
        case (kc)
            8'd80:   return 0;
            8'd79:   return 1;
            8'd81:   return 2;
            8'd82:   return 3;
            default: return -1;
        endcase
    endfunction

    task automatic model_reset();
        m_f = 0; m_x = 480; m_y = 240; m_dir = 0; m_mom = 0;
        m_boost_end = -100000; m_rf = -100000;
        m_moving = 0; m_boost = 0; m_spawn = 0;
    endtask

    task automatic model_edge();
        int  req, prev, step, ox, oy;
        bit  boosted, locked, blk;
        m_f++;
        if (respawn) begin
            m_x = 480; m_y = 240; m_dir = 0; m_mom = 0;
            m_rf = m_f; m_boost_end = m_f; m_moving = 0;
        end else begin
            boosted = (m_f <= m_boost_end);
            if (speed_pickup) m_boost_end = m_f + 600;
            locked = (m_f - m_rf) < 60;
            ox = m_x; oy = m_y;
            if (locked) begin
                m_mom = 0;
            end else begin
                req = key_dir(keycode0);
                if (req < 0) req = key_dir(keycode1);
                if (req < 0) begin
                    m_mom = 0;
                end else begin
                    prev  = m_dir;
                    m_dir = req;
                    case (req)
                        0:       blk = barrier_collision[1] || (m_x - 8 <= 1);
                        1:       blk = barrier_collision[0] || (m_x + 8 >= 639);
                        2:       blk = barrier_collision[2] || (m_y + 8 >= 479);
                        default: blk = barrier_collision[3] || (m_y - 8 <= 1);
                    endcase
                    if (blk) begin
                        m_mom = 0;
                    end else begin
                        if (m_mom >= 4 && req != prev) m_mom = 0;
                        step = boosted ? 3 : ((m_mom >= 4) ? 2 : 1);
                        if (m_mom < 4) m_mom++;
                        case (req)
                            0:       m_x = (m_x - step < 10) ? 10 : m_x - step;
                            1:       m_x = (m_x + step > 631) ? 631 : m_x + step;
                            2:       m_y = (m_y + step > 471) ? 471 : m_y + step;
                            default: m_y = (m_y - step < 10) ? 10 : m_y - step;
                        endcase
                    end
                end
            end
            m_moving = (ox != m_x) || (oy != m_y);
        end
        m_boost = (m_f < m_boost_end);
        m_spawn = (m_f - m_rf) < 60;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic [7:0] kc0;
        logic [7:0] kc1;
        logic [3:0] bar;
        logic [9:0] ex;
        logic [9:0] ey;
        logic [1:0] edir;
        logic       em;
    } vec_t;

    vec_t vecs[14];
    vec_t v;
    logic [7:0] keys[6];
    int         run_left;
    logic [24:0] exp_pack;

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        // Ramp from reset, idle, barrier, then two-slot priority cases.
        vecs[0]  = '{8'd79, 8'd0,  4'h0, 10'd481, 10'd240, 2'b01, 1'b1};
        vecs[1]  = '{8'd79, 8'd0,  4'h0, 10'd482, 10'd240, 2'b01, 1'b1};
        vecs[2]  = '{8'd79, 8'd0,  4'h0, 10'd483, 10'd240, 2'b01, 1'b1};
        vecs[3]  = '{8'd79, 8'd0,  4'h0, 10'd484, 10'd240, 2'b01, 1'b1};
        vecs[4]  = '{8'd79, 8'd0,  4'h0, 10'd486, 10'd240, 2'b01, 1'b1};
        vecs[5]  = '{8'd79, 8'd0,  4'h0, 10'd488, 10'd240, 2'b01, 1'b1};
        vecs[6]  = '{8'd0,  8'd0,  4'h0, 10'd488, 10'd240, 2'b01, 1'b0};
        vecs[7]  = '{8'd79, 8'd0,  4'h1, 10'd488, 10'd240, 2'b01, 1'b0};
        vecs[8]  = '{8'd80, 8'd0,  4'h1, 10'd487, 10'd240, 2'b00, 1'b1};
        vecs[9]  = '{8'd0,  8'd0,  4'h0, 10'd487, 10'd240, 2'b00, 1'b0};
        vecs[10] = '{8'd0,  8'd81, 4'h0, 10'd487, 10'd241, 2'b10, 1'b1};
        vecs[11] = '{8'd0,  8'd0,  4'h0, 10'd487, 10'd241, 2'b10, 1'b0};
        vecs[12] = '{8'd80, 8'd79, 4'h0, 10'd486, 10'd241, 2'b00, 1'b1};
        vecs[13] = '{8'd5,  8'd6,  4'h0, 10'd486, 10'd241, 2'b00, 1'b0};

        keys[0] = 8'd0;  keys[1] = 8'd79; keys[2] = 8'd80;
        keys[3] = 8'd81; keys[4] = 8'd82; keys[5] = 8'd44;

        clear_inputs();
        Reset_n = 1'b1;
        #1;
        Reset_n = 1'b0;
        #2;
        check("reset_x", pos_x, 480);
        check("reset_y", pos_y, 240);
        check("reset_dir", direction, 0);
        check("reset_flags", {moving, boost_active, spawning}, 0);
        check("size", size, 8);
        @(posedge frame_clk);
        #1;
        Reset_n = 1'b1;

        for (int i = 0; i < 14; i++) begin
            v = vecs[i];
            keycode0 = v.kc0; keycode1 = v.kc1; barrier_collision = v.bar;
            tick();
            check($sformatf("vec%0d_x", i), pos_x, v.ex);
            check($sformatf("vec%0d_y", i), pos_y, v.ey);
            check($sformatf("vec%0d_dir", i), direction, v.edir);
            check($sformatf("vec%0d_moving", i), moving, v.em);
        end
        clear_inputs();

        // Clamp against the right wall: 4 ramp + 69 cruise frames reach x=628.
        keycode0 = 8'd79;
        for (int i = 0; i < 73; i++) tick();
        check("clamp_start", pos_x, 628);
        tick();
        check("clamp_630", {pos_x, moving}, {10'd630, 1'b1});
        tick();
        check("clamp_631", {pos_x, moving}, {10'd631, 1'b1});
        tick();
        check("clamp_hold", {pos_x, moving, direction}, {10'd631, 1'b0, 2'b01});
        clear_inputs();

        // Boost: pulse at k=0, reload at k=300, single pulse at k=1000.
        for (int k = 0; k <= 1600; k++) begin
            keycode0 = (k >= 1 && k <= 5) ? 8'd82 : ((k >= 897 && k <= 901) ? 8'd81 : 8'd0);
            speed_pickup = (k == 0 || k == 300 || k == 1000);
            tick();
            speed_pickup = 1'b0;
            if (k == 0) check("boost_on", {boost_active, pos_y}, {1'b1, 10'd241});
            if (k >= 1 && k <= 5)
                check($sformatf("boost_up%0d", k), pos_y, 10'(241 - 3 * k));
            if (k == 599 || k == 600 || k == 899 || k == 1000 || k == 1599)
                check($sformatf("boost_act%0d", k), boost_active, 1);
            if (k == 900 || k == 950 || k == 1600)
                check($sformatf("boost_off%0d", k), boost_active, 0);
            if (k >= 897 && k <= 900)
                check($sformatf("boost_down%0d", k), pos_y, 10'(226 + 3 * (k - 896)));
            if (k == 901) check("step_back_to_2", pos_y, 240);
        end
        clear_inputs();

        // Respawn with a simultaneous pickup while moving right from x=500.
        pulse_reset();
        keycode0 = 8'd79;
        for (int i = 0; i < 12; i++) tick();
        check("respawn_start", pos_x, 500);
        respawn = 1'b1;
        speed_pickup = 1'b1;
        tick();
        respawn = 1'b0;
        speed_pickup = 1'b0;
        check("respawn_pos", {pos_x, pos_y, direction}, {10'd480, 10'd240, 2'b00});
        check("respawn_flags", {boost_active, spawning}, 2'b01);
        for (int j = 1; j <= 59; j++) begin
            tick();
            check($sformatf("spawn_lock%0d", j), {pos_x, moving, spawning},
                  {10'd480, 1'b0, 1'b1});
        end
        tick();
        check("spawn_release", {pos_x, spawning, direction, boost_active, moving},
              {10'd481, 1'b0, 2'b01, 1'b0, 1'b1});
        tick();
        check("spawn_step1", pos_x, 482);
        clear_inputs();

        // Randomised run against the reference model.
        pulse_reset();
        model_reset();
        run_left = 0;
        for (int i = 0; i < 3000; i++) begin
            if (run_left == 0) begin
                keycode0 = keys[$urandom_range(0, 5)];
                keycode1 = keys[$urandom_range(0, 5)];
                run_left = $urandom_range(1, 80);
            end
            run_left--;
            barrier_collision = ($urandom_range(0, 9) == 0) ? 4'($urandom) : 4'h0;
            respawn      = ($urandom_range(0, 499) == 0) || (i == 1000);
            speed_pickup = ($urandom_range(0, 199) == 0) || (i == 1020);
            model_edge();
            tick();
            exp_pack = {10'(m_x), 10'(m_y), 2'(m_dir), m_moving, m_boost, m_spawn};
            check($sformatf("rand%0d", i),
                  {pos_x, pos_y, direction, moving, boost_active, spawning}, exp_pack);
        end
        clear_inputs();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/tank_motion.md
# tank_motion

Parametrised tank movement controller for the VGA tank game, one instance per player, clocked once per frame. It generalises the fixed-step tank controllers with several additions: configurable key map and arena, a two-keycode input with priority, acceleration ramp, timed speed boost, respawn with spawn-lock, and clamped wall approach. Position and direction outputs feed the tank sprite, bullet and collision logic.

## Interface
- X_CENTER, 480: respawn/reset X position
- Y_CENTER, 240: respawn/reset Y position
- X_MIN / X_MAX, 1 / 639: arena X limits
- Y_MIN / Y_MAX, 1 / 479: arena Y limits
- SIZE, 8: tank half-size, driven on `size`
- KEY_LEFT / KEY_RIGHT / KEY_DOWN / KEY_UP, 80 / 79 / 81 / 82: HID keycodes
- BASE_STEP, 2: cruise step in pixels; must be ≥1
- BOOST_STEP, 3: step while boosted; must be ≥1
- RAMP_FRAMES, 4: number of step-1 moves before cruise; must be ≥1
- BOOST_FRAMES, 600: boost duration in frames
- SPAWN_FRAMES, 60: movement lock after respawn
- DIR_RESET, 2'b00: direction after reset/respawn
- frame_clk  in  1  frame-rate clock; everything is on its rising edge
- Reset_n  in  1  asynchronous, active-low reset
- keycode0  in  8  first key slot; higher priority
- keycode1  in  8  second key slot
- speed_pickup  in  1  one-frame pulse that starts or reloads the boost
- respawn  in  1  one-frame pulse that returns the tank to centre
- barrier_collision  in  4  bit0 right blocked, bit1 left blocked, bit2 down blocked, bit3 up blocked
- pos_x, pos_y  out  10  tank centre
- size  out  10  constant SIZE
- direction  out  2  00 left, 01 right, 10 down, 11 up
- moving  out  1  position changed on the last edge
- boost_active  out  1  boost timer is non-zero
- spawning  out  1  spawn-lock active

## Operation
- **Key decode:** keycode0 is checked first; if it matches no direction key, keycode1 is checked. If neither matches, there is no request.
- **States:** IDLE, RAMP, CRUISE, SPAWN.
  - IDLE → RAMP: a request arrives and the move is not blocked.
  - RAMP: step is 1. A move counter increments on each move. On the RAMP_FRAMES-th move, the next state is CRUISE.
  - CRUISE: step is BASE_STEP.
  - RAMP/CRUISE → IDLE: no request, or the move is blocked.
  - CRUISE → RAMP: the request direction differs from `direction`. The counter restarts and this frame's step is 1.
- **Boost step:** while boost_active=1, the step is BOOST_STEP in RAMP and CRUISE. The ramp counter still advances.
- **Direction:** `direction` updates to any decoded request, including a blocked one, and is held when there is no request.
- **Blocked move:** a move is blocked when the matching barrier_collision bit is 1, or the tank is already at the limit. The limit is pos_x−SIZE ≤ X_MIN for left, pos_x+SIZE ≥ X_MAX for right, and likewise for Y. A blocked move gives no position change and moving=0.
- **Clamped move:** a move that would overshoot is clamped to the limit: X_MIN+SIZE+1, X_MAX−SIZE, Y_MIN+SIZE+1 or Y_MAX−SIZE.
- **Arithmetic:** position arithmetic is 11-bit, so nothing wraps below zero or above 1023.
- **Boost timer:** speed_pickup loads BOOST_FRAMES whether or not a boost is already running (reload, not accumulate). The timer decrements each frame while non-zero.
- **Respawn:** respawn sets position to centre, direction to DIR_RESET, clears the boost timer and loads the spawn timer with SPAWN_FRAMES. The state goes to SPAWN.
  - In SPAWN, keys are ignored and spawning=1.
  - When the timer expires, the state goes to IDLE.
  - speed_pickup in the same frame as respawn is dropped. speed_pickup during SPAWN is accepted.
- **Priority:** Reset_n low > respawn > movement.

## Timing
- **Reset:** Reset_n low immediately sets pos=(X_CENTER, Y_CENTER), direction=DIR_RESET, state IDLE, all counters 0, and moving, boost_active and spawning all 0.
- **Inputs and outputs:** all inputs are sampled at the edge; all outputs are registered and reflect that edge, giving 1 frame of latency.
- **Boost latency:** a pickup sampled at edge n gives boost_active=1 after edge n, and the boosted step is first used at edge n+1.
- **Spawn duration:** a respawn sampled at edge n gives spawning=1 for the SPAWN_FRAMES frames after edges n … n+SPAWN_FRAMES−1. The first move possible is at edge n+SPAWN_FRAMES, with step 1.
- **Respawn mid-ramp or mid-boost:** all momentum is discarded.

## Test plan
- **Reset and ramp:** with Reset_n low, expect (480,240), direction 00 and all flags 0. Release reset and hold keycode0=79 for 6 frames; expect pos_x = 481, 482, 483, 484, 486, 488, with moving=1 and direction 01.
- **Clamp:** cruise right from 628; expect pos_x = 630, then 631, then 631 held with moving=0.
- **Barrier:** with barrier_collision=0001 and key 79, expect x unchanged, direction 01 and state IDLE. Then key 80; expect a step-1 move left.
- **Boost:** pulse speed_pickup, then hold key 82; expect y to decrease by 3 per frame. After 600 frames boost_active drops to 0 and the step returns to 2. A re-pulse at frame 300 extends the boost to frame 900.
- **Respawn:** at x=500, pulse respawn and speed_pickup together while holding 79. Expect (480,240) and boost_active=0, with spawning=1 for 60 frames and no movement. Frame 61 gives x=481.
- **Two-slot priority:** keycode0=0 with keycode1=81 moves down. keycode0=80 with keycode1=79 moves left.
